mul_issue_ctrl: RTL and testbench
=================================

MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 40, max cycles from startE to done before abort.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  EX stage holds a multiply instruction.
REQ-005 SHALL have port req_funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU; other values never paired with req_valid.
REQ-006 SHALL have ports req_rs1, req_rs2  in  32  source operands.
REQ-007 SHALL have port req_rd  in  5  destination register.
REQ-008 SHALL have port flush  in  1  kill the EX-stage instruction.
REQ-009 SHALL have port stall_o  out  1  hold IF/ID/EX stages.
REQ-010 SHALL have ports wb_valid (1), wb_rd (5), wb_data (32)  out  result toward writeback.
REQ-011 SHALL have port timeout_o  out  1  one-cycle abort pulse.
REQ-012 SHALL have ports startE (1), mul_opcode (2), operand1 (32), operand2 (32)  out  multiplier launch.
REQ-013 SHALL have ports done (1), result_multiply (32), mul_use (1)  in  multiplier status/result.

Function
REQ-014 SHALL implement FSM IDLE, LAUNCH, WAIT, DRAIN, RESP.
REQ-015 IDLE: req_valid & ~flush SHALL latch rs1, rs2, rd, opcode (funct3[1:0], 00/01/10/11) and go LAUNCH.
REQ-016 LAUNCH: startE SHALL be 1 for exactly this cycle, operand1/operand2/mul_opcode held from latch until leaving WAIT/DRAIN; next state WAIT.
REQ-017 WAIT: done=1 SHALL capture result_multiply into wb_data and go RESP; otherwise stay.
REQ-018 RESP: wb_valid=1 one cycle with latched rd/result; stall_o=0; next state IDLE.
REQ-019 stall_o SHALL equal req_valid & (state != RESP), combinational.
REQ-020 Latency from acceptance to wb_valid SHALL be multiplier latency + 3 cycles; no new startE while mul_use=1.
REQ-021 flush in LAUNCH or WAIT SHALL go DRAIN (startE still issued in LAUNCH); DRAIN waits for done, discards result, returns IDLE, never asserts wb_valid.
REQ-022 flush in RESP SHALL suppress wb_valid; flush in IDLE SHALL block acceptance.
REQ-023 Timeout counter SHALL clear at startE, count in WAIT/DRAIN; at TIMEOUT_CYCLES go IDLE, pulse timeout_o, no wb_valid.
REQ-024 done outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-025 rst SHALL force IDLE and zero all outputs, latches, counter in the next edge, including mid-operation.
REQ-026 A request with req_valid=1 during rst SHALL be accepted only on the first cycle after rst deasserts.

Configuration
REQ-027 Macro MUL_RESULT_CACHE_EN SHALL enable a one-entry cache {valid, opcode, rs1, rs2, result}.
REQ-028 With macro: IDLE acceptance with matching valid entry SHALL go directly to RESP (latency 1), no startE; entry updated on every RESP from WAIT; invalidated on reset and timeout.
REQ-029 Without macro: no cache storage; every request launches the multiplier.

Structure
REQ-030 Package mul_ctrl_pkg SHALL hold the state enum, funct3 and mul_opcode constants, TIMEOUT_CYCLES default.
REQ-031 Cache SHALL be sub-module mul_result_cache, instantiated only under MUL_RESULT_CACHE_EN.

Verification
REQ-032 MUL 7 x 6, rd=5 -> one startE, mul_opcode=00, wb_valid with wb_rd=5, wb_data=42; stall_o high until RESP.
REQ-033 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> wb_data=0xFFFFFFFE; MULH 0x80000000 x 2 -> 0xFFFFFFFF.
REQ-034 flush 5 cycles after startE -> state DRAIN, no wb_valid, next request launches only after done.
REQ-035 done never asserted -> timeout_o pulse 40 cycles after startE, FSM IDLE, no wb_valid.
REQ-036 rst mid-WAIT -> all outputs 0 next cycle; following MUL 3 x 3 returns 9.
REQ-037 With MUL_RESULT_CACHE_EN, repeated MUL 7 x 6 -> no second startE, wb_valid one cycle after acceptance, wb_data=42.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared definitions for the multiply issue controller.
// Contents: FSM state encodings, funct3 / mul_opcode constants, the default
// timeout, the result-cache entry layout and the funct3 -> opcode mapping.
package mul_ctrl_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 40;

    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_LAUNCH = 3'd1;
    localparam state_t ST_WAIT   = 3'd2;
    localparam state_t ST_DRAIN  = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef struct packed {
        logic        valid;
        logic [1:0]  opcode;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] result;
    } cache_entry_t;

    function automatic logic [1:0] funct3_to_opcode(input logic [2:0] f3);
        case (f3)
            F3_MUL:    return OP_MUL;
            F3_MULH:   return OP_MULH;
            F3_MULHSU: return OP_MULHSU;
            F3_MULHU:  return OP_MULHU;
            default:   return OP_MUL;
        endcase
    endfunction

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Bundle of all non-clock signals of the multiply issue controller.
//   pipeline side  : req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
//                    stall_o, wb_valid, wb_rd, wb_data, timeout_o
//   multiplier side: startE, mul_opcode, operand1, operand2,
//                    done, result_multiply, mul_use
// slave  = the controller itself.
// master = its environment (EX stage plus multiplier).
interface mul_issue_ctrl_if;
    logic        req_valid;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [4:0]  req_rd;
    logic        flush;
    logic        stall_o;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_o;
    logic        startE;
    logic [1:0]  mul_opcode;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        done;
    logic [31:0] result_multiply;
    logic        mul_use;

    modport slave (
        input  req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
        input  done, result_multiply, mul_use,
        output stall_o, wb_valid, wb_rd, wb_data, timeout_o,
        output startE, mul_opcode, operand1, operand2
    );

    modport master (
        output req_valid, req_funct3, req_rs1, req_rs2, req_rd, flush,
        output done, result_multiply, mul_use,
        input  stall_o, wb_valid, wb_rd, wb_data, timeout_o,
        input  startE, mul_opcode, operand1, operand2
    );
endinterface

// File: rtl/mul_result_cache.sv
// One-entry cache of the last completed multiply {valid, opcode, rs1, rs2, result}.
// Ports: clk, rst (sync, active-high); inv clears the entry; wr_en with
//        wr_* loads it; lk_* is the lookup key, hit/hit_result the answer.
// Only instantiated when MUL_RESULT_CACHE_EN is defined.
module mul_result_cache
    import mul_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        inv,
    input  logic        wr_en,
    input  logic [1:0]  wr_opcode,
    input  logic [31:0] wr_rs1,
    input  logic [31:0] wr_rs2,
    input  logic [31:0] wr_result,
    input  logic [1:0]  lk_opcode,
    input  logic [31:0] lk_rs1,
    input  logic [31:0] lk_rs2,
    output logic        hit,
    output logic [31:0] hit_result
);
    cache_entry_t entry_q, entry_d;

    always_comb begin
        entry_d = entry_q;
        if (inv) begin
            entry_d.valid = 1'b0;
        end else if (wr_en) begin
            entry_d.valid  = 1'b1;
            entry_d.opcode = wr_opcode;
            entry_d.rs1    = wr_rs1;
            entry_d.rs2    = wr_rs2;
            entry_d.result = wr_result;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) entry_q <= '0;
        else     entry_q <= entry_d;
    end

    assign hit = entry_q.valid && (entry_q.opcode == lk_opcode) &&
                 (entry_q.rs1 == lk_rs1) && (entry_q.rs2 == lk_rs2);
    assign hit_result = entry_q.result;
endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller between the EX stage and an iterative multiplier.
// Ports: clk, rst (sync, active-high), bus (mul_issue_ctrl_if.slave) carrying
//        the EX request / flush / stall / writeback signals and the
//        multiplier launch / status signals.
// Optional: define MUL_RESULT_CACHE_EN to add a one-entry result cache that
//           answers a repeated request without launching the multiplier.
//
// state  | meaning
// IDLE   | waiting for an unflushed request
// LAUNCH | startE high, operands presented to the multiplier
// WAIT   | waiting for done, timeout counter running
// DRAIN  | request flushed, waiting for done to discard the result
// RESP   | wb_valid high for one cycle, stall released
module mul_issue_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic            clk,
    input  logic            rst,
    mul_issue_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    // Down-counter loaded at startE; reaching zero in WAIT/DRAIN marks cycle TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [31:0]      rs1_q, rs1_d, rs2_q, rs2_d, data_q, data_d;
    logic [4:0]       rd_q, rd_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        req_take, cnt_tc, in_busy, tmo, cache_hit;
    logic [1:0]  req_op;
    logic [31:0] cache_data;

    assign req_op   = funct3_to_opcode(bus.req_funct3);
    assign req_take = bus.req_valid && !bus.flush;
    assign cnt_tc   = (cnt_q == '0);
    assign in_busy  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
    // A done on the terminal cycle wins over the abort.
    assign tmo      = in_busy && !bus.done && cnt_tc;

`ifdef MUL_RESULT_CACHE_EN
    logic cache_wr;
    assign cache_wr = (state_q == ST_WAIT) && bus.done && !bus.flush;

    mul_result_cache u_cache (
        .clk        (clk),
        .rst        (rst),
        .inv        (tmo),
        .wr_en      (cache_wr),
        .wr_opcode  (op_q),
        .wr_rs1     (rs1_q),
        .wr_rs2     (rs2_q),
        .wr_result  (bus.result_multiply),
        .lk_opcode  (req_op),
        .lk_rs1     (bus.req_rs1),
        .lk_rs2     (bus.req_rs2),
        .hit        (cache_hit),
        .hit_result (cache_data)
    );
`else
    assign cache_hit  = 1'b0;
    assign cache_data = '0;
`endif

    always_comb begin
        state_d = state_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        rd_d    = rd_q;
        op_d    = op_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                // A busy multiplier only blocks requests that actually need it.
                if (req_take && (cache_hit || !bus.mul_use)) begin
                    rs1_d = bus.req_rs1;
                    rs2_d = bus.req_rs2;
                    rd_d  = bus.req_rd;
                    op_d  = req_op;
                    if (cache_hit) begin
                        data_d  = cache_data;
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_LAUNCH;
                    end
                end
            end
            ST_LAUNCH: begin
                cnt_d   = CNT_LOAD;
                state_d = bus.flush ? ST_DRAIN : ST_WAIT;
            end
            ST_WAIT: begin
                if (bus.done) begin
                    // Flush coinciding with done: the result is already here, drop it.
                    if (bus.flush) begin
                        state_d = ST_IDLE;
                    end else begin
                        data_d  = bus.result_multiply;
                        state_d = ST_RESP;
                    end
                end else if (cnt_tc) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (bus.flush) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (bus.done || cnt_tc) state_d = ST_IDLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            op_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.startE     = (state_q == ST_LAUNCH);
    assign bus.mul_opcode = op_q;
    assign bus.operand1   = rs1_q;
    assign bus.operand2   = rs2_q;
    assign bus.wb_valid   = (state_q == ST_RESP) && !bus.flush;
    assign bus.wb_rd      = rd_q;
    assign bus.wb_data    = data_q;
    assign bus.timeout_o  = tmo;
    assign bus.stall_o    = bus.req_valid && (state_q != ST_RESP);
endmodule

// File: tb/tb_mul_issue_ctrl.sv
module tb_mul_issue_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    int   exp_start = 0;

    mul_issue_ctrl_if bus ();

    mul_issue_ctrl #(.TIMEOUT_CYCLES(40)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (bus.startE === 1'b1) n_start++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic present(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] rd);
        bus.req_valid  = 1'b1;
        bus.req_funct3 = f3;
        bus.req_rs1    = a;
        bus.req_rs2    = b;
        bus.req_rd     = rd;
    endtask

    // Called just after the negedge of the expected LAUNCH cycle.
    task automatic launch_chk(input string tag, input logic [1:0] opc, input logic [31:0] a,
                              input logic [31:0] b);
        chk({tag, ".startE"},   32'(bus.startE), 32'd1);
        chk({tag, ".opcode"},   32'(bus.mul_opcode), 32'(opc));
        chk({tag, ".operand1"}, bus.operand1, a);
        chk({tag, ".operand2"}, bus.operand2, b);
        chk({tag, ".stall"},    32'(bus.stall_o), 32'd1);
        exp_start++;
        bus.mul_use = 1'b1;
    endtask

    task automatic respond(input string tag, input int lat, input logic [31:0] res,
                           input logic [4:0] rd, input logic fr);
        repeat (lat) begin
            @(negedge clk); #1;
            chk({tag, ".wait_wb"},    32'(bus.wb_valid), 32'd0);
            chk({tag, ".wait_stall"}, 32'(bus.stall_o), 32'd1);
        end
        bus.done = 1'b1;
        bus.result_multiply = res;
        @(negedge clk);
        bus.done = 1'b0;
        bus.result_multiply = '0;
        bus.mul_use = 1'b0;
        bus.flush = fr;
        #1;
        chk({tag, ".wb_valid"}, 32'(bus.wb_valid), fr ? 32'd0 : 32'd1);
        chk({tag, ".wb_rd"},    32'(bus.wb_rd), 32'(rd));
        chk({tag, ".wb_data"},  bus.wb_data, res);
        chk({tag, ".resp_stall"}, 32'(bus.stall_o), 32'd0);
        bus.req_valid = 1'b0;
        bus.flush = 1'b0;
        @(negedge clk); #1;
        chk({tag, ".wb_drop"}, 32'(bus.wb_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [2:0] f3, input logic [1:0] opc,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input int lat, input logic [31:0] res, input logic fr);
        present(f3, a, b, rd);
        #1;
        chk({tag, ".idle_stall"}, 32'(bus.stall_o), 32'd1);
        @(negedge clk); #1;
        launch_chk(tag, opc, a, b);
        respond(tag, lat, res, rd, fr);
    endtask

    initial begin
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_funct3 = '0;
        bus.req_rs1 = '0;
        bus.req_rs2 = '0;
        bus.req_rd = '0;
        bus.flush = 1'b0;
        bus.done = 1'b0;
        bus.result_multiply = '0;
        bus.mul_use = 1'b0;

        // Request held through reset must wait for rst to fall.
        present(3'b000, 32'd7, 32'd6, 5'd5);
        repeat (3) begin
            @(negedge clk); #1;
            chk("rst.startE",   32'(bus.startE), 32'd0);
            chk("rst.wb_valid", 32'(bus.wb_valid), 32'd0);
            chk("rst.operand1", bus.operand1, 32'd0);
            chk("rst.timeout",  32'(bus.timeout_o), 32'd0);
        end
        rst = 1'b0;

        run_op("mul7x6", 3'b000, 2'b00, 32'd7, 32'd6, 5'd5, 2, 32'd42, 1'b0);
        chk("mul7x6.n_start", 32'(n_start), 32'd1);
        run_op("mulhu", 3'b011, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 3, 32'hFFFF_FFFE, 1'b0);
        run_op("mulh", 3'b001, 2'b01, 32'h8000_0000, 32'd2, 5'd9, 1, 32'hFFFF_FFFF, 1'b0);
        run_op("mulhsu", 3'b010, 2'b10, 32'hFFFF_FFFF, 32'd2, 5'd10, 4, 32'hFFFF_FFFF, 1'b0);
        run_op("flush_resp", 3'b000, 2'b00, 32'd10, 32'd10, 5'd1, 2, 32'd100, 1'b1);

        // Flush in IDLE blocks acceptance.
        present(3'b000, 32'd12, 32'd12, 5'd2);
        bus.flush = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("flush_idle.startE", 32'(bus.startE), 32'd0);
        end
        bus.flush = 1'b0;
        @(negedge clk); #1;
        launch_chk("flush_idle", 2'b00, 32'd12, 32'd12);
        respond("flush_idle", 2, 32'd144, 5'd2, 1'b0);

        // Busy multiplier blocks a new startE.
        present(3'b000, 32'd13, 32'd2, 5'd11);
        bus.mul_use = 1'b1;
        repeat (2) begin
            @(negedge clk); #1;
            chk("mul_use.startE", 32'(bus.startE), 32'd0);
        end
        bus.mul_use = 1'b0;
        @(negedge clk); #1;
        launch_chk("mul_use", 2'b00, 32'd13, 32'd2);
        respond("mul_use", 2, 32'd26, 5'd11, 1'b0);

        // done while IDLE is ignored.
        @(negedge clk);
        bus.done = 1'b1;
        bus.result_multiply = 32'hDEAD;
        @(negedge clk);
        bus.done = 1'b0;
        bus.result_multiply = '0;
        #1;
        chk("idle_done.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("idle_done.wb_data",  bus.wb_data, 32'd26);

        // Flush five cycles after startE: drain, no writeback, next launch waits for done.
        present(3'b000, 32'd4, 32'd5, 5'd3);
        @(negedge clk); #1;
        launch_chk("flush_wait", 2'b00, 32'd4, 32'd5);
        repeat (4) begin
            @(negedge clk); #1;
            chk("flush_wait.wb_valid", 32'(bus.wb_valid), 32'd0);
        end
        @(negedge clk);
        bus.flush = 1'b1;
        bus.req_valid = 1'b0;
        #1;
        chk("flush_wait.flush_wb", 32'(bus.wb_valid), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        present(3'b000, 32'd11, 32'd3, 5'd7);
        #1;
        chk("drain.startE", 32'(bus.startE), 32'd0);
        repeat (2) begin
            @(negedge clk); #1;
            chk("drain.startE_hold", 32'(bus.startE), 32'd0);
            chk("drain.wb_valid",    32'(bus.wb_valid), 32'd0);
        end
        bus.done = 1'b1;
        bus.result_multiply = 32'd20;
        @(negedge clk);
        bus.done = 1'b0;
        bus.result_multiply = '0;
        bus.mul_use = 1'b0;
        #1;
        chk("drain_done.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("drain_done.startE",   32'(bus.startE), 32'd0);
        @(negedge clk); #1;
        launch_chk("after_drain", 2'b00, 32'd11, 32'd3);
        respond("after_drain", 2, 32'd33, 5'd7, 1'b0);

        // done never arrives: abort pulse 40 cycles after startE.
        present(3'b000, 32'd9, 32'd9, 5'd12);
        @(negedge clk); #1;
        launch_chk("tmo", 2'b00, 32'd9, 32'd9);
        for (int i = 1; i < 40; i++) begin
            @(negedge clk); #1;
            chk("tmo.early", 32'(bus.timeout_o), 32'd0);
            chk("tmo.wb_valid", 32'(bus.wb_valid), 32'd0);
        end
        @(negedge clk); #1;
        chk("tmo.pulse",    32'(bus.timeout_o), 32'd1);
        chk("tmo.pulse_wb", 32'(bus.wb_valid), 32'd0);
        bus.req_valid = 1'b0;
        bus.mul_use = 1'b0;
        @(negedge clk); #1;
        chk("tmo.after", 32'(bus.timeout_o), 32'd0);
        present(3'b000, 32'd3, 32'd7, 5'd13);
        @(negedge clk); #1;
        launch_chk("post_tmo", 2'b00, 32'd3, 32'd7);
        respond("post_tmo", 1, 32'd21, 5'd13, 1'b0);

        // Reset in the middle of WAIT.
        present(3'b000, 32'd5, 32'd5, 5'd9);
        @(negedge clk); #1;
        launch_chk("rst_wait", 2'b00, 32'd5, 32'd5);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        bus.mul_use = 1'b0;
        #1;
        chk("rst_wait.startE",   32'(bus.startE), 32'd0);
        chk("rst_wait.opcode",   32'(bus.mul_opcode), 32'd0);
        chk("rst_wait.operand1", bus.operand1, 32'd0);
        chk("rst_wait.operand2", bus.operand2, 32'd0);
        chk("rst_wait.wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wait.wb_rd",    32'(bus.wb_rd), 32'd0);
        chk("rst_wait.wb_data",  bus.wb_data, 32'd0);
        chk("rst_wait.timeout",  32'(bus.timeout_o), 32'd0);
        chk("rst_wait.stall",    32'(bus.stall_o), 32'd0);
        run_op("mul3x3", 3'b000, 2'b00, 32'd3, 32'd3, 5'd4, 2, 32'd9, 1'b0);

`ifdef MUL_RESULT_CACHE_EN
        run_op("cache_fill", 3'b000, 2'b00, 32'd7, 32'd6, 5'd5, 2, 32'd42, 1'b0);
        present(3'b000, 32'd7, 32'd6, 5'd6);
        #1;
        chk("cache.stall", 32'(bus.stall_o), 32'd1);
        @(negedge clk); #1;
        chk("cache.wb_valid", 32'(bus.wb_valid), 32'd1);
        chk("cache.wb_data",  bus.wb_data, 32'd42);
        chk("cache.wb_rd",    32'(bus.wb_rd), 32'd6);
        chk("cache.startE",   32'(bus.startE), 32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk); #1;
        chk("cache.wb_drop", 32'(bus.wb_valid), 32'd0);
`endif

        @(negedge clk); #1;
        chk("n_start.total", 32'(n_start), 32'(exp_start));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
